// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO window with a TX FIFO, drop counter
// and, when DMEM_RESPONDER_CYCLE_CTR_EN is defined, a loadable free-running cycle counter.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_LOG2  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FFF0;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFF1;
    localparam logic [31:0] ADDR_DROPS  = 32'hFFFF_FFF2;
`ifdef DMEM_RESPONDER_CYCLE_CTR_EN
    localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_FFF3;
`endif

    logic [31:0]          mem [DEPTH_RAM()];
    logic [31:0]          fifo [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic [31:0]          drops;

    logic in_ram;
    logic full;
    logic empty;
    logic wr_tx;
    logic push;
    logic pop;
    logic drop;
    logic [3:0]  count_field;
    logic [31:0] status;

    function automatic int DEPTH_RAM();
        return 1 << ADDR_WIDTH;
    endfunction

    assign in_ram      = (address_dmem[31:ADDR_WIDTH] == '0);
    // Count can only reach DEPTH with its top bit set, so that bit alone is "full".
    assign full        = count[FIFO_LOG2];
    assign empty       = (count == '0);
    assign wr_tx       = wren && (address_dmem == ADDR_TXDATA);
    assign push        = wr_tx && !full && !reset;
    assign drop        = wr_tx && full && !reset;
    assign pop         = tx_valid && tx_ready;
    assign count_field = 4'(count);
    assign status      = {24'b0, count_field, 2'b0, empty, full};

    assign tx_valid = !empty;
    assign tx_data  = empty ? 32'b0 : fifo[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset && wren && in_ram) begin
            mem[address_dmem[ADDR_WIDTH-1:0]] <= data;
        end
    end

    // FIFO storage is never reset; the pointers and count alone decide what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_LOG2+1)'(1);
                2'b01:   count <= count - (FIFO_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drops <= '0;
        end else if (wren && (address_dmem == ADDR_DROPS)) begin
            drops <= '0;
        end else if (drop && (drops != 32'hFFFF_FFFF)) begin
            drops <= drops + 32'd1;
        end
    end

`ifdef DMEM_RESPONDER_CYCLE_CTR_EN
    logic [31:0] cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles <= '0;
        end else if (wren && (address_dmem == ADDR_CYCLES)) begin
            cycles <= data;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        q_dmem = '0;
        if (in_ram) begin
            q_dmem = mem[address_dmem[ADDR_WIDTH-1:0]];
        end else begin
            case (address_dmem)
                ADDR_STATUS: q_dmem = status;
                ADDR_DROPS:  q_dmem = drops;
`ifdef DMEM_RESPONDER_CYCLE_CTR_EN
                ADDR_CYCLES: q_dmem = cycles;
`endif
                default:     q_dmem = '0;
            endcase
        end
    end

endmodule
